// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the nibble-serial adder
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_slice.sv
// rtl/nibble_add_slice.sv - combinational 4-bit adder slice with carry in/out
module nibble_add_slice
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign s     = total[NIBBLE_W-1:0];
    assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder sequenced one nibble per clock; ADDER_SUB_EN adds subtract
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           carry_q;
    logic [N-1:0][NIBBLE_W-1:0]     a_q;
    logic [N-1:0][NIBBLE_W-1:0]     b_q;
    logic [N-1:0][NIBBLE_W-1:0]     acc_q;
    logic [N-1:0][NIBBLE_W-1:0]     acc_d;
    logic [WIDTH:0]                 sum_q;
    logic                           busy_q;
    logic                           done_q;

    logic [NIBBLE_W-1:0]            slice_a;
    logic [NIBBLE_W-1:0]            slice_b;
    logic [NIBBLE_W-1:0]            slice_s;
    logic                           slice_cout;
    logic                           carry_seed;
    logic                           last_nibble;

`ifdef ADDER_SUB_EN
    logic                           sub_q;

    // Subtraction is a + ~b + 1: invert b per nibble, seed carry with 1.
    assign slice_b    = b_q[cnt_q] ^ {NIBBLE_W{sub_q}};
    assign carry_seed = sub;
`else
    assign slice_b    = b_q[cnt_q];
    assign carry_seed = 1'b0;
`endif

    assign slice_a     = a_q[cnt_q];
    assign last_nibble = (cnt_q == CNT_W'(N - 1));

    nibble_add_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        acc_d        = acc_q;
        acc_d[cnt_q] = slice_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
`ifdef ADDER_SUB_EN
                        sub_q   <= sub;
`endif
                        cnt_q   <= '0;
                        carry_q <= carry_seed;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_cout;
                    if (last_nibble) begin
                        cnt_q   <= '0;
                        sum_q   <= {slice_cout, acc_d};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub_in;
    logic         busy;
    logic         done;
    logic [W:0]   sum;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_in),
        .b     (b_in),
`ifdef ADDER_SUB_EN
        .sub   (sub_in),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int unsigned full;
        if (s) full = int'(x) + int'(~y & 16'hFFFF) + 1;
        else   full = int'(x) + int'(y);
        return full[W:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; operand inputs are scrambled during RUN to show they are ignored.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] exp;
        exp    = ref_sum(x, y, s);
        start  = 1'b1;
        a_in   = x;
        b_in   = y;
        sub_in = s;
        tick();
        start  = 1'b0;
        check({tag, "_accept"}, {busy, done}, 2'b10);
        for (int i = 1; i < N; i++) begin
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            sub_in = 1'($urandom);
            tick();
            check({tag, "_run"}, {busy, done}, 2'b10);
        end
        tick();
        check({tag, "_done"}, {busy, done}, 2'b01);
        check({tag, "_sum"}, sum, exp);
        tick();
        check({tag, "_done_clr"}, {busy, done}, 2'b00);
        check({tag, "_sum_hold"}, sum, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        sub_in = 1'b0;
        tick();
        tick();
        check("reset_flags", {busy, done}, 2'b00);
        check("reset_sum", sum, 0);
        rst_n = 1'b1;
        tick();

        run_op("zero", 16'h0000, 16'h0000, 1'b0);
        run_op("carry_chain", 16'h0001, 16'hFFFF, 1'b0);

        // Back-to-back: start held through DONE.
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'hFFFF;
        tick();
        a_in = 16'h0000;
        b_in = 16'h000F;
        for (int i = 1; i < N; i++) begin
            tick();
            check("b2b_run1", {busy, done}, 2'b10);
        end
        tick();
        check("b2b_done1", {busy, done}, 2'b01);
        check("b2b_sum1", sum, 17'h1FFFE);
        tick();
        start = 1'b0;
        check("b2b_restart", {busy, done}, 2'b10);
        check("b2b_sum1_hold", sum, 17'h1FFFE);
        for (int i = 1; i < N; i++) begin
            tick();
            check("b2b_run2", {busy, done}, 2'b10);
        end
        tick();
        check("b2b_done2", {busy, done}, 2'b01);
        check("b2b_sum2", sum, 17'h0000F);
        tick();

        // Start re-pulsed mid-RUN must be ignored.
        start = 1'b1;
        a_in  = 16'h1234;
        b_in  = 16'h4321;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'hFFFF;
        tick();
        check("midrun_busy", {busy, done}, 2'b10);
        tick();
        start = 1'b0;
        tick();
        check("midrun_done", {busy, done}, 2'b01);
        check("midrun_sum", sum, 17'h05555);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrun_single_done", {busy, done}, 2'b00);
        end

        // Reset at cnt=2 aborts the operation.
        start = 1'b1;
        a_in  = 16'h1234;
        b_in  = 16'h1111;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_flags", {busy, done}, 2'b00);
        check("abort_sum", sum, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", {busy, done}, 2'b00);
        end
        run_op("after_abort", 16'hABCD, 16'h1357, 1'b0);

`ifdef ADDER_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1);
        check("sub_borrow_const", sum, 17'h0FFFE);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1);
        check("sub_noborrow_const", sum, 17'h10002);
`endif

        for (int k = 0; k < 25; k++) begin
            logic s;
`ifdef ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op("rand", W'($urandom), W'($urandom), s);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
